mem_bus_arbiter: RTL and testbench

- Shares the single 32-bit CPU memory bus (addr/data/mem_read/mem_write/mem_ready) between up to NUM_REQ masters: CPU fetch/data port, DMA, debug loader.
- Sits between the masters and the memory/peripheral fabric.
- Runs one transaction at a time. Uses a registered req/ack handshake per master and holds each transaction until mem_ready.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_bus_arbiter_rr_picker.sv | 67 ++++++
 rtl/mem_bus_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory bus arbiter.
//   - arb_state_e  : transaction FSM encoding (IDLE/BUSY/DONE)
//   - ARB_FIXED / ARB_RR : arbitration mode selectors
//   - ARB_ERR_RDATA : read data returned on an aborted transaction
//   - DEFAULT_TIMEOUT : default BUSY-cycle limit for the optional timeout
//   - done_rdata() : selects the rdata value captured when a transaction ends
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_FIXED       = 0;
  localparam int unsigned ARB_RR          = 1;
  localparam logic [31:0] ARB_ERR_RDATA   = 32'hDEADBEEF;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // Writes return zero, aborted transactions return the error pattern,
  // reads return whatever the memory presented on the completing cycle.
  function automatic logic [31:0] done_rdata(input logic        timed_out,
                                             input logic        we,
                                             input logic [31:0] mem_rdata);
    logic [31:0] r;
    if (timed_out)  r = ARB_ERR_RDATA;
    else if (we)    r = 32'h0;
    else            r = mem_rdata;
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// arb_rr_picker: chooses one winner among active requests.
//   clk, rst     : clock, synchronous active-high reset (pointer -> 0)
//   req          : per-master request vector
//   update       : pulse when the current winner is actually granted;
//                  advances the round-robin pointer to winner+1 (wrapping)
//   winner       : index of the chosen master
//   valid        : at least one request is active
// In fixed mode the search always starts at index 0 so the lowest active
// index wins; in round-robin mode it starts at the registered pointer.
module arb_rr_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     start;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]     offset;
  logic [IDX_W:0]       sum;

  assign start = (ARB_MODE == ARB_FIXED) ? '0 : ptr_q;

  // Rotate requests so that bit 0 is the master at the search start; the
  // lowest set bit of the rotated vector is then the winner's distance.
  assign req_dbl = {req, req} >> start;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    offset = '0;
    valid  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        valid  = 1'b1;
        offset = IDX_W'(i);
      end
    end
  end

  // Map the rotated distance back to an absolute index, wrapping mod NUM_REQ.
  assign sum    = {1'b0, start} + {1'b0, offset};
  assign winner = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                               : sum[IDX_W-1:0];

  always_comb begin
    ptr_d = ptr_q;
    if (update) begin
      ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 32-bit memory bus between NUM_REQ masters,
// one transaction at a time (IDLE -> BUSY -> DONE -> IDLE).
//   clk, rst              : clock, synchronous active-high reset
//   req/req_we            : per-master request and write flag
//   req_addr/req_wdata    : flattened per-master address / write data,
//                           master i at [32*i +: 32]
//   ack/err               : one-cycle completion / error pulse (one-hot)
//   rdata                 : read data, meaningful while ack is high
//   gnt/busy              : current owner and bus-occupied flag (BUSY/DONE)
//   mem_addr/mem_wdata    : memory address / write data
//   mem_read/mem_write    : memory strobes, high throughout BUSY
//   mem_rdata/mem_ready   : memory read data / completion
// Optional feature macro: MEM_ARB_TIMEOUT_EN. When defined, a BUSY cycle
// counter aborts a transaction after TIMEOUT_CYCLES cycles without
// mem_ready (ack+err pulse, rdata = ARB_ERR_RDATA). When undefined BUSY
// waits indefinitely and err never asserts.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned ARB_MODE       = ARB_RR,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    err,
  output logic [31:0]           rdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  busy,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 16;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [IDX_W-1:0]   pick_winner;
  logic               pick_valid;
  logic               pick_update;
  logic               timeout_hit;

  logic [31:0] addr_arr  [NUM_REQ];
  logic [31:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[32*gi +: 32];
    assign wdata_arr[gi] = req_wdata[32*gi +: 32];
  end

  arb_rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .ARB_MODE (ARB_MODE),
    .IDX_W    (IDX_W)
  ) u_picker (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (pick_update),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Zero outside BUSY, so it is already clear on the first BUSY cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != BUSY)  cnt_d = '0;
    else if (!mem_ready)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Fires on the BUSY cycle whose increment would reach the limit;
  // mem_ready on that same cycle takes precedence.
  assign timeout_hit = !mem_ready && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);
`else
  assign timeout_hit = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0) && (CNT_W != 0);
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    rdata_d     = rdata_q;
    ack_d       = '0;
    err_d       = '0;
    pick_update = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          pick_update        = 1'b1;
          owner_d            = pick_winner;
          addr_d             = addr_arr[pick_winner];
          wdata_d            = wdata_arr[pick_winner];
          we_d               = req_we[pick_winner];
          mem_read_d         = ~req_we[pick_winner];
          mem_write_d        = req_we[pick_winner];
          gnt_d              = '0;
          gnt_d[pick_winner] = 1'b1;
          busy_d             = 1'b1;
          state_d            = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready || timeout_hit) begin
          rdata_d        = done_rdata(!mem_ready, we_q, mem_rdata);
          ack_d[owner_q] = 1'b1;
          err_d[owner_q] = !mem_ready;
          mem_read_d     = 1'b0;
          mem_write_d    = 1'b0;
          state_d        = DONE;
        end
      end
      DONE: begin
        // No arbitration here: a request still high is seen next in IDLE.
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ack_q       <= '0;
      err_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: a round-robin and a fixed-priority
// instance share the same stimulus. A transaction-level model predicts
// every output each cycle; directed scenarios add literal expectations.
module tb_mem_bus_arbiter;

  localparam int N  = 3;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req, req_we;
  logic [31:0]     a_addr  [N];
  logic [31:0]     a_wdata [N];
  logic [N*32-1:0] req_addr, req_wdata;
  logic [31:0]     mem_rdata;
  logic            mem_ready;

  assign req_addr  = {a_addr[2],  a_addr[1],  a_addr[0]};
  assign req_wdata = {a_wdata[2], a_wdata[1], a_wdata[0]};

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic [N-1:0] ack_o [2];
  logic [N-1:0] err_o [2];
  logic [N-1:0] gnt_o [2];
  logic [31:0]  rdata_o [2];
  logic [31:0]  maddr_o [2];
  logic [31:0]  mwdata_o [2];
  logic         busy_o [2];
  logic         mrd_o [2];
  logic         mwr_o [2];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_REQ(N), .ARB_MODE(1), .TIMEOUT_CYCLES(TO)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack_o[0]), .err(err_o[0]), .rdata(rdata_o[0]),
    .gnt(gnt_o[0]), .busy(busy_o[0]), .mem_addr(maddr_o[0]), .mem_wdata(mwdata_o[0]),
    .mem_read(mrd_o[0]), .mem_write(mwr_o[0]), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_bus_arbiter #(.NUM_REQ(N), .ARB_MODE(0), .TIMEOUT_CYCLES(TO)) dut_fx (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack_o[1]), .err(err_o[1]), .rdata(rdata_o[1]),
    .gnt(gnt_o[1]), .busy(busy_o[1]), .mem_addr(maddr_o[1]), .mem_wdata(mwdata_o[1]),
    .mem_read(mrd_o[1]), .mem_write(mwr_o[1]), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 = bus free, 1 = transfer in progress, 2 = completion cycle
  int          m_phase [2];
  int          m_owner [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic        m_err   [2];
  int          m_cnt   [2];
  int          m_ptr   [2];
  logic        m_fresh [2];
  bit          model_ok = 0;
  int          cyc = 0;

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  initial begin
    int w;
    forever begin
      @(posedge clk);
      cyc++;
      for (int m = 0; m < 2; m++) begin
        if (rst) begin
          m_phase[m] = 0; m_owner[m] = 0; m_we[m] = 1'b0;
          m_addr[m] = 32'h0; m_wdata[m] = 32'h0; m_rdata[m] = 32'h0;
          m_err[m] = 1'b0; m_cnt[m] = 0; m_ptr[m] = 0; m_fresh[m] = 1'b1;
        end else if (m_phase[m] == 0) begin
          if (req != '0) begin
            w = pick(req, (m == 0) ? m_ptr[m] : 0);
            m_ptr[m]   = (w + 1) % N;
            m_owner[m] = w;
            m_we[m]    = req_we[w];
            m_addr[m]  = a_addr[w];
            m_wdata[m] = a_wdata[w];
            m_cnt[m]   = 0;
            m_err[m]   = 1'b0;
            m_fresh[m] = 1'b0;
            m_phase[m] = 1;
          end
        end else if (m_phase[m] == 1) begin
          if (mem_ready) begin
            m_rdata[m] = m_we[m] ? 32'h0 : mem_rdata;
            m_phase[m] = 2;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else begin
            m_cnt[m] = m_cnt[m] + 1;
            if (m_cnt[m] >= TO) begin
              m_rdata[m] = 32'hDEADBEEF;
              m_err[m]   = 1'b1;
              m_phase[m] = 2;
            end
          end
`endif
        end else begin
          m_phase[m] = 0;
        end
      end
      model_ok = 1;
    end
  end

  // ---------------- per-cycle compare + event log ----------------
  int          ev_idx_rr [$];
  int          ev_idx_fx [$];
  int          ev_cyc    [$];
  logic [31:0] ev_rdata  [$];
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
    return -1;
  endfunction

  initial begin
    logic [N-1:0] e_gnt, e_ack, e_err;
    string nm;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        for (int m = 0; m < 2; m++) begin
          nm    = (m == 0) ? "rr" : "fx";
          e_gnt = (m_phase[m] != 0) ? (N'(1) << m_owner[m]) : '0;
          e_ack = (m_phase[m] == 2) ? (N'(1) << m_owner[m]) : '0;
          e_err = (m_phase[m] == 2 && m_err[m]) ? (N'(1) << m_owner[m]) : '0;
          chk({nm, ".busy"}, 32'(busy_o[m]), 32'(m_phase[m] != 0));
          chk({nm, ".gnt"},  32'(gnt_o[m]),  32'(e_gnt));
          chk({nm, ".ack"},  32'(ack_o[m]),  32'(e_ack));
          chk({nm, ".err"},  32'(err_o[m]),  32'(e_err));
          chk({nm, ".mem_read"},  32'(mrd_o[m]), 32'(m_phase[m] == 1 && !m_we[m]));
          chk({nm, ".mem_write"}, 32'(mwr_o[m]), 32'(m_phase[m] == 1 && m_we[m]));
          if (m_phase[m] == 1 || m_fresh[m]) begin
            chk({nm, ".mem_addr"},  maddr_o[m],  m_addr[m]);
            chk({nm, ".mem_wdata"}, mwdata_o[m], m_wdata[m]);
          end
          if (m_phase[m] == 2 || m_fresh[m])
            chk({nm, ".rdata"}, rdata_o[m], m_rdata[m]);
        end
        if (ack_o[0] != '0) begin
          ev_idx_rr.push_back(oh_idx(ack_o[0]));
          ev_cyc.push_back(cyc);
          ev_rdata.push_back(rdata_o[0]);
        end
        if (ack_o[1] != '0) ev_idx_fx.push_back(oh_idx(ack_o[1]));
        if (mrd_o[0]) rd_cnt++;
        if (mwr_o[0]) wr_cnt++;
      end
    end
  end

  task automatic clr_log();
    ev_idx_rr.delete(); ev_idx_fx.delete(); ev_cyc.delete(); ev_rdata.delete();
    rd_cnt = 0; wr_cnt = 0;
  endtask

  function automatic int q_at(input int q [$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  int exp_rr_order [4] = '{0, 1, 2, 0};

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b1; req = '0; req_we = '0; mem_ready = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < N; i++) begin
      a_addr[i]  = 32'h0000_1000 * (i + 1);
      a_wdata[i] = 32'h5000_0000 + i;
    end
    repeat (2) @(negedge clk);
    chk("reset.busy",     32'(busy_o[0]), 32'h0);
    chk("reset.ack",      32'(ack_o[0]),  32'h0);
    chk("reset.gnt",      32'(gnt_o[0]),  32'h0);
    chk("reset.mem_addr", maddr_o[0],     32'h0);
    chk("reset.rdata",    rdata_o[0],     32'h0);
    rst = 1'b0;
    @(negedge clk);

    // single read: master 1, ready on 2nd BUSY cycle
    clr_log();
    a_addr[1] = 32'h0000_8000; req = 3'b010;
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("read.ack",   32'(ack_o[0]), 32'h2);
    chk("read.rdata", rdata_o[0],    32'h1234_5678);
    req = '0; mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("read.strobe_cycles", 32'(rd_cnt), 32'd2);
    chk("read.ack_count",     32'(ev_idx_rr.size()), 32'd1);

    // contention: all request, memory always ready
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    clr_log();
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_0000; req = 3'b111;
    repeat (12) @(negedge clk);
    req = '0; mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("cont.rr_count", 32'(ev_idx_rr.size()), 32'd4);
    chk("cont.fx_count", 32'(ev_idx_fx.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont.rr_order%0d", k), 32'(q_at(ev_idx_rr, k)), 32'(exp_rr_order[k]));
      chk($sformatf("cont.fx_order%0d", k), 32'(q_at(ev_idx_fx, k)), 32'd0);
    end
    for (int k = 1; k < 4; k++)
      chk($sformatf("cont.spacing%0d", k), 32'(q_at(ev_cyc, k) - q_at(ev_cyc, k - 1)), 32'd3);

    // write: master 2, ready on 3rd BUSY cycle
    clr_log();
    a_addr[2] = 32'h0000_3010; a_wdata[2] = 32'hCAFE_F00D; req_we = 3'b100;
    mem_rdata = 32'h1111_1111; req = 3'b100;
    repeat (3) @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("write.ack",       32'(ack_o[0]), 32'h4);
    chk("write.mem_write", 32'(mwr_o[0]), 32'h0);
    req = '0; req_we = '0; mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("write.write_cycles", 32'(wr_cnt), 32'd3);
    chk("write.read_cycles",  32'(rd_cnt), 32'd0);
    chk("write.rdata",        (ev_rdata.size() > 0) ? ev_rdata[0] : 32'hFFFF_FFFF, 32'h0);

    // reset on the 3rd BUSY cycle, request held through it
    req = 3'b001;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.busy",     32'(busy_o[0]), 32'h0);
    chk("rstmid.mem_read", 32'(mrd_o[0]),  32'h0);
    chk("rstmid.ack",      32'(ack_o[0]),  32'h0);
    rst = 1'b0;
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk);
    chk("rstmid.regrant_rr", 32'(ack_o[0]), 32'h1);
    chk("rstmid.regrant_fx", 32'(ack_o[1]), 32'h1);
    req = '0; mem_ready = 1'b0;
    @(negedge clk);

    // master drops request on the first BUSY cycle
    req = 3'b010;
    @(negedge clk); req = '0; mem_ready = 1'b1;
    @(negedge clk);
    chk("drop.ack", 32'(ack_o[0]), 32'h2);
    mem_ready = 1'b0;
    @(negedge clk);

    // memory never answers
    req = 3'b001;
`ifdef MEM_ARB_TIMEOUT_EN
    repeat (5) @(negedge clk);
    chk("timeout.ack",   32'(ack_o[0]), 32'h1);
    chk("timeout.err",   32'(err_o[0]), 32'h1);
    chk("timeout.rdata", rdata_o[0],    32'hDEAD_BEEF);
    req = '0;
    @(negedge clk);
`else
    repeat (20) @(negedge clk);
    chk("nowait.busy", 32'(busy_o[0]), 32'h1);
    chk("nowait.err",  32'(err_o[0]),  32'h0);
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
